alu_fsm: RTL and testbench

- Parametrised successor to the 4-bit add/subtract state machine.
- Generalises operand width and adds an 8-operation opcode set and status flags (carry, zero, negative, overflow).
- Adds a valid/ready handshake on both input and output; results are held under back-pressure.
- Adds a saturating completed-operation counter.
- Sits between a command source and a result consumer in the datapath exercises; one operation is in flight at a time.

---
 rtl/alu_fsm_if.sv | 30 +++
 rtl/alu_fsm.sv | 119 +++++++++++
 tb/tb_alu_fsm.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_fsm_if.sv
// alu_fsm_if: command/result handshake bundle for alu_fsm.
// The master drives commands and back-pressure; the slave returns results.
interface alu_fsm_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out_res, flag_c, flag_z, flag_n, flag_v, op_count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out_res, flag_c, flag_z, flag_n, flag_v, op_count
    );
endinterface

// File: rtl/alu_fsm.sv
// alu_fsm: multi-cycle parametrised ALU with valid/ready handshakes,
// status flags and a saturating count of consumed results.
module alu_fsm #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic      clk,
    input logic      reset,
    alu_fsm_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_c;
    logic             r_z;
    logic             r_n;
    logic             r_v;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_res;
    logic [SH_W-1:0]  w_sh;
    logic             w_c;
    logic             w_v;
    logic             w_take;

    assign bus.in_ready  = (r_state == IDLE) || (r_state == DONE && bus.out_ready);
    assign bus.out_valid = r_valid;
    assign bus.out_res   = r_res;
    assign bus.flag_c    = r_c;
    assign bus.flag_z    = r_z;
    assign bus.flag_n    = r_n;
    assign bus.flag_v    = r_v;
    assign bus.op_count  = r_cnt;

    assign w_take = bus.in_valid && bus.in_ready;
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    // The top bit of the widened difference is the unsigned borrow (a < b).
    assign w_dif  = {1'b0, r_a} - {1'b0, r_b};
    assign w_sh   = r_b[SH_W-1:0];

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_op)
            3'd0: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            3'd1: begin
                w_res = w_dif[MSB:0];
                w_c   = w_dif[WIDTH];
                w_v   = (r_a[MSB] != r_b[MSB]) && (w_dif[MSB] != r_a[MSB]);
            end
            3'd2: w_res = r_a & r_b;
            3'd3: w_res = r_a | r_b;
            3'd4: w_res = r_a ^ r_b;
            3'd5: w_res = r_a << w_sh;
            3'd6: w_res = r_a >> w_sh;
            default: begin
                w_res = {{(WIDTH-1){1'b0}}, w_dif[WIDTH]};
                w_c   = w_dif[WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                LOAD: r_state <= EXEC;
                EXEC: begin
                    r_state <= DONE;
                    r_valid <= 1'b1;
                    r_res   <= w_res;
                    r_c     <= w_c;
                    r_z     <= (w_res == '0);
                    r_n     <= w_res[MSB];
                    r_v     <= w_v;
                end
                default: begin
                    if (r_state == DONE && bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                        if (~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
                    end
                    // A new command may be taken on the same edge that retires the last result.
                    if (w_take) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_state <= LOAD;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_fsm.sv
// tb_alu_fsm: directed vectors for alu_fsm, checked every cycle against an
// arithmetic/latency model plus hand-computed literal expectations.
module tb_alu_fsm;
    localparam int W = 8;
    localparam int C = 16;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    alu_fsm_if #(.WIDTH(W), .CNT_W(C)) bus ();

    alu_fsm #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    // Reference arithmetic written in plain integers and signed ranges.
    task automatic calc(input int op, input int a, input int b, output int r, output bit c, output bit v);
        int s;
        c = 0;
        v = 0;
        case (op)
            0: begin
                s = a + b;
                r = s % M;
                c = s >= M;
                s = sgn(a) + sgn(b);
                v = s > M / 2 - 1 || s < -M / 2;
            end
            1: begin
                r = (a - b + M) % M;
                c = a < b;
                s = sgn(a) - sgn(b);
                v = s > M / 2 - 1 || s < -M / 2;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a << (b % W)) % M;
            6: r = a >> (b % W);
            default: begin
                r = (a < b) ? 1 : 0;
                c = a < b;
            end
        endcase
    endtask

    bit m_init = 0, m_flight, m_valid, m_c, m_z, m_n, m_v;
    int m_age, m_res, m_cnt, p_op, p_a, p_b;

    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            m_init  = 1;
            m_flight = 0;
            m_valid = 0;
            m_age   = 0;
            m_res   = 0;
            {m_c, m_z, m_n, m_v} = 4'b0;
            m_cnt   = 0;
        end else if (m_init) begin
            acc = bus.in_valid && (!m_flight || (m_valid && bus.out_ready));
            if (m_valid && bus.out_ready) begin
                m_valid  = 0;
                m_flight = 0;
                if (m_cnt != (1 << C) - 1) m_cnt++;
            end
            if (m_flight && !m_valid) begin
                m_age++;
                if (m_age == 2) begin
                    m_valid = 1;
                    calc(p_op, p_a, p_b, m_res, m_c, m_v);
                    m_z = m_res == 0;
                    m_n = m_res >= M / 2;
                end
            end
            if (acc) begin
                m_flight = 1;
                m_age    = 0;
                p_op     = int'(bus.op);
                p_a      = int'(bus.a);
                p_b      = int'(bus.b);
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", bus.in_ready, !m_flight || (m_valid && bus.out_ready));
            chk("out_valid", bus.out_valid, m_valid);
            chk("out_res", bus.out_res, m_res);
            chk("flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, {m_c, m_z, m_n, m_v});
            chk("op_count", bus.op_count, m_cnt);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int op, input int a, input int b);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.op = 3'(op);
        bus.a  = W'(a);
        bus.b  = W'(b);
        #1;
        while (!bus.in_ready && k < 30) begin
            tick();
            k++;
        end
        if (!bus.in_ready) chk("accept timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_res(input string nm, input int res, input logic [3:0] fl);
        int lat = 0;
        while (!bus.out_valid && lat < 30) begin
            tick();
            lat++;
        end
        chk({nm, " latency"}, lat, 2);
        chk({nm, " res"}, bus.out_res, res);
        chk({nm, " flags"}, {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, fl);
    endtask

    task automatic run(input string nm, input int op, input int a, input int b,
                       input int res, input logic [3:0] fl, input int cnt);
        send(op, a, b);
        wait_res(nm, res, fl);
        tick();
        chk({nm, " consumed"}, bus.out_valid, 0);
        chk({nm, " count"}, bus.op_count, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = '0;
        bus.a  = '0;
        bus.b  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_res", bus.out_res, 0);
        chk("rst flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 0);
        chk("rst count", bus.op_count, 0);
        // flags are {c, z, n, v}
        run("add200_100", 0, 200, 100, 44, 4'b1000, 1);
        run("add127_1", 0, 127, 1, 128, 4'b0011, 2);
        run("sub0_1", 1, 0, 1, 255, 4'b1010, 3);
        run("add255_1", 0, 255, 1, 0, 4'b1100, 4);
        run("xor", 4, 8'h5A, 8'h5A, 0, 4'b0100, 5);
        run("shl", 5, 8'h81, 8'h0B, 8'h08, 4'b0000, 6);
        run("shr", 6, 8'h80, 7, 8'h01, 4'b0000, 7);
        run("cmp", 7, 3, 9, 1, 4'b1000, 8);
        run("sub100_156", 1, 100, 156, 200, 4'b1011, 9);
        run("or", 3, 8'hA0, 8'h05, 8'hA5, 4'b0010, 10);
        bus.out_ready = 1'b0;
        send(2, 8'hF0, 8'h3C);
        wait_res("and", 8'h30, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold valid", bus.out_valid, 1);
            chk("hold res", bus.out_res, 8'h30);
            chk("hold in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b1;
        bus.op        = 3'd1;
        bus.a         = 8'd10;
        bus.b         = 8'd3;
        bus.out_ready = 1'b1;
        #1;
        chk("b2b in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b consumed", bus.out_valid, 0);
        chk("b2b count", bus.op_count, 11);
        wait_res("sub10_3", 7, 4'b0000);
        tick();
        chk("sub10_3 count", bus.op_count, 12);
        send(0, 2, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst out_valid", bus.out_valid, 0);
        chk("midrst out_res", bus.out_res, 0);
        chk("midrst count", bus.op_count, 0);
        chk("midrst in_ready", bus.in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst no result", bus.out_valid, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
